// File: rtl/hall_feedback_monitor.sv
// Hall sensor front end for the BLDC motor controller.
//
// Synchronises and debounces the three raw Hall pins. It also decodes the
// commutation sector and the rotation direction. It measures the period
// between accepted edges for speed estimation. It raises no_feedback when the
// rotor stops producing edges.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   hall_raw     raw Hall pins {C,B,A}, asynchronous to clk
//   hall_signal  debounced Hall code
//   sector       decoded sector 0..5, 7 for an invalid code
//   direction    1 = forward, 0 = reverse
//   hall_edge    one-cycle pulse per accepted code change
//   period       clk cycles between the last two valid adjacent edges
//   period_valid period holds a genuine measurement
//   hall_error   one-cycle pulse on an invalid code or a non-adjacent jump
//   no_feedback  stall flag, set while no edge has been seen for TIMEOUT_CYCLES
//
// Optional feature: define HALL_PERIOD_AVG_EN to report the mean of the last
// four measurements instead of the latest one.

module hall_feedback_monitor #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000,
  parameter int unsigned PERIOD_W        = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          hall_raw,
  output logic [2:0]          hall_signal,
  output logic [2:0]          sector,
  output logic                direction,
  output logic                hall_edge,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                hall_error,
  output logic                no_feedback
);

  localparam int unsigned SyncW = 3 * SYNC_STAGES;
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0]      DbTarget   = DbW'(DEBOUNCE_CYCLES);
  localparam logic [PERIOD_W-1:0] TimeoutCnt = PERIOD_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]          SecInvalid = 3'd7;

  typedef enum logic [1:0] {StAcquire, StRun, StStall} state_e;

  function automatic logic [2:0] decode_sector(input logic [2:0] code);
    case (code)
      3'b101:  decode_sector = 3'd0;
      3'b100:  decode_sector = 3'd1;
      3'b110:  decode_sector = 3'd2;
      3'b010:  decode_sector = 3'd3;
      3'b011:  decode_sector = 3'd4;
      3'b001:  decode_sector = 3'd5;
      default: decode_sector = SecInvalid;
    endcase
  endfunction

  // Synchroniser: a shift register of 3-bit stages, oldest stage on top.
  logic [SyncW-1:0] sync_q;
  logic [2:0]       sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SyncW-4:0], hall_raw};
  end

  assign sync = sync_q[SyncW-1 -: 3];

  // Debounce: stab_d counts the cycles that sync has matched the candidate.
  // The count includes the current cycle. A code is accepted when that count
  // reaches the target, so the latency is SYNC_STAGES + DEBOUNCE_CYCLES.
  logic [2:0]     cand_q;
  logic [DbW-1:0] stab_q, stab_d;
  logic           accept;

  always_comb begin
    if (sync != cand_q)         stab_d = DbW'(1);
    else if (stab_q < DbTarget) stab_d = stab_q + DbW'(1);
    else                        stab_d = stab_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q <= '0;
      stab_q <= '0;
    end else begin
      cand_q <= sync;
      stab_q <= stab_d;
    end
  end

  // Main state.
  state_e              state_q, state_d;
  logic [2:0]          hs_q, hs_d;
  logic [2:0]          sec_q, sec_d;
  logic                dir_q, dir_d;
  logic                edge_q, edge_d;
  logic                err_q, err_d;
  logic                nf_q;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pv_q, pv_d;
  logic                meas;

  logic [2:0] new_sec, sec_next, sec_prev;
  logic       step_fwd, step_rev;

  assign accept   = (stab_d == DbTarget) && (sync != hs_q);
  assign new_sec  = decode_sector(sync);
  assign sec_next = (sec_q == 3'd5) ? 3'd0 : sec_q + 3'd1;
  assign sec_prev = (sec_q == 3'd0) ? 3'd5 : sec_q - 3'd1;
  assign step_fwd = (sec_q != SecInvalid) && (new_sec != SecInvalid) && (new_sec == sec_next);
  assign step_rev = (sec_q != SecInvalid) && (new_sec != SecInvalid) && (new_sec == sec_prev);

  always_comb begin
    state_d = state_q;
    hs_d    = hs_q;
    sec_d   = sec_q;
    dir_d   = dir_q;
    edge_d  = 1'b0;
    err_d   = 1'b0;
    meas    = 1'b0;
    count_d = (&count_q) ? count_q : count_q + PERIOD_W'(1);

    if (accept) begin
      // An accepted edge takes priority over a timeout in the same cycle.
      edge_d = 1'b1;
      hs_d   = sync;
      sec_d  = new_sec;
      if (new_sec == SecInvalid) begin
        err_d   = 1'b1;
        state_d = StAcquire;
      end else if (sec_q == SecInvalid) begin
        state_d = StRun;
        count_d = PERIOD_W'(1);
      end else if (step_fwd || step_rev) begin
        dir_d   = step_fwd;
        count_d = PERIOD_W'(1);
        state_d = StRun;
        // Only an edge that was already in RUN has a reference point.
        meas    = (state_q == StRun);
      end else begin
        err_d   = 1'b1;
        state_d = StAcquire;
      end
    end else if ((state_q != StStall) && (count_q == TimeoutCnt)) begin
      state_d = StStall;
    end
  end

`ifdef HALL_PERIOD_AVG_EN
  // Four-deep history with a running sum. The history is emptied whenever
  // the block is not in RUN. Partial windows never reach period.
  logic [3:0][PERIOD_W-1:0] hist_q, hist_d;
  logic [PERIOD_W+1:0]      sum_q, sum_d;
  logic [2:0]               fill_q, fill_d;

  always_comb begin
    hist_d = hist_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (state_d != StRun) begin
      hist_d = '0;
      sum_d  = '0;
      fill_d = '0;
    end else if (meas) begin
      hist_d = {hist_q[2:0], count_q};
      sum_d  = sum_q + {2'b00, count_q} - {2'b00, hist_q[3]};
      fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      sum_q  <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end
`endif

  // period_valid clears whenever the block leaves RUN or enters it afresh.
  always_comb begin
    period_d = period_q;
    pv_d     = pv_q;
    if ((state_d != StRun) || (state_q != StRun)) begin
      pv_d = 1'b0;
    end else if (meas) begin
`ifdef HALL_PERIOD_AVG_EN
      if (fill_d == 3'd4) begin
        period_d = sum_d[PERIOD_W+1:2];
        pv_d     = 1'b1;
      end
`else
      period_d = count_q;
      pv_d     = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StAcquire;
      hs_q     <= 3'b000;
      sec_q    <= SecInvalid;
      dir_q    <= 1'b1;
      edge_q   <= 1'b0;
      err_q    <= 1'b0;
      nf_q     <= 1'b0;
      count_q  <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_q     <= hs_d;
      sec_q    <= sec_d;
      dir_q    <= dir_d;
      edge_q   <= edge_d;
      err_q    <= err_d;
      nf_q     <= (state_d == StStall);
      count_q  <= count_d;
      period_q <= period_d;
      pv_q     <= pv_d;
    end
  end

  assign hall_signal  = hs_q;
  assign sector       = sec_q;
  assign direction    = dir_q;
  assign hall_edge    = edge_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign hall_error   = err_q;
  assign no_feedback  = nf_q;

endmodule

// File: tb/tb_hall_feedback_monitor.sv
module tb_hall_feedback_monitor;

  localparam int unsigned PW = 24;
  localparam int unsigned TO = 2000;
  localparam int unsigned LAT = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    hall_raw = 3'b000;
  logic [2:0]    hall_signal;
  logic [2:0]    sector;
  logic          direction;
  logic          hall_edge;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          hall_error;
  logic          no_feedback;

  always #5 clk = ~clk;

  hall_feedback_monitor #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(16),
    .TIMEOUT_CYCLES(TO),
    .PERIOD_W(PW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hall_raw(hall_raw),
    .hall_signal(hall_signal),
    .sector(sector),
    .direction(direction),
    .hall_edge(hall_edge),
    .period(period),
    .period_valid(period_valid),
    .hall_error(hall_error),
    .no_feedback(no_feedback)
  );

  typedef struct packed {
    logic [2:0]    hs;
    logic [2:0]    sec;
    logic          dir;
    logic [PW-1:0] per;
    logic          pv;
    logic          err;
    logic          nf;
  } snap_t;

  localparam logic [2:0] FWD [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  localparam logic [2:0] REV [5] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    edge_cnt = 0;
  snap_t exp_q[$];
  int    exp_cyc_q[$];
  snap_t obs;
  int    obs_cyc;
  logic  obs_timeout;
  logic  obs_edge_next;
  logic  obs_err_next;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (hall_edge === 1'b1) edge_cnt++;

  function automatic snap_t mk(input logic [2:0] hs, input logic [2:0] sec, input logic dir,
                               input int per, input logic pv, input logic err, input logic nf);
    snap_t s;
    s.hs = hs; s.sec = sec; s.dir = dir; s.per = PW'(per); s.pv = pv; s.err = err; s.nf = nf;
    return s;
  endfunction

  function automatic snap_t sample();
    return snap_t'({hall_signal, sector, direction, period, period_valid, hall_error,
                    no_feedback});
  endfunction

  // Drive a code at a falling edge, push its expectation and capture the
  // outputs at the accepted edge. Returns at a falling edge hold cycles after
  // the drive.
  task automatic apply_code(input logic [2:0] code, input int hold, input snap_t e);
    int t;
    int n;
    hall_raw = code;
    t = cyc;
    n = 0;
    exp_q.push_back(e);
    exp_cyc_q.push_back(t + LAT);
    while (n < 40 && hall_edge !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    obs_timeout = (hall_edge !== 1'b1);
    obs = sample();
    obs_cyc = cyc;
    @(negedge clk);
    obs_edge_next = hall_edge;
    obs_err_next = hall_error;
    while (cyc < t + hold) @(negedge clk);
  endtask

  task automatic test_reset();
    snap_t r;
    r = mk(3'b000, 3'd7, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sample() !== r || hall_edge !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got %h edge %b want %h edge 0", sample(), hall_edge, r);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (sample() !== r || hall_edge !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got %h edge %b want %h edge 0", sample(), hall_edge, r);
    end
  endtask

  task automatic test_forward();
    snap_t es;
    int ec;
    for (int i = 0; i < 6; i++) begin
      apply_code(FWD[i], 1000, mk(FWD[i], 3'(i), 1'b1, (i == 0) ? 0 : 1000, i != 0, 1'b0, 1'b0));
      es = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      checks++;
      if (obs_timeout || obs !== es) begin
        errors++;
        $display("FAIL fwd[%0d] outputs: got %h timeout %b want %h", i, obs, obs_timeout, es);
      end
      checks++;
      if (obs_cyc != ec) begin
        errors++;
        $display("FAIL fwd[%0d] latency: got cycle %0d want %0d", i, obs_cyc, ec);
      end
      checks++;
      if (obs_edge_next !== 1'b0 || obs_err_next !== 1'b0) begin
        errors++;
        $display("FAIL fwd[%0d] pulse_width: got edge/err %b%b want 00", i, obs_edge_next,
                 obs_err_next);
      end
    end
  endtask

  task automatic test_reverse();
    snap_t es;
    int ec;
    // The first reverse edge closes the last 1000-cycle forward interval.
    for (int i = 0; i < 5; i++) begin
      apply_code(REV[i], 500, mk(REV[i], 3'(4 - i), 1'b0, (i == 0) ? 1000 : 500, 1'b1, 1'b0,
                                 1'b0));
      es = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      checks++;
      if (obs_timeout || obs !== es || obs_cyc != ec) begin
        errors++;
        $display("FAIL rev[%0d]: got %h at %0d timeout %b want %h at %0d", i, obs, obs_cyc,
                 obs_timeout, es, ec);
      end
    end
  endtask

  task automatic test_glitch();
    int e0;
    e0 = edge_cnt;
    hall_raw = 3'b100;
    repeat (10) @(negedge clk);
    hall_raw = 3'b101;
    repeat (100) @(negedge clk);
    checks++;
    if (edge_cnt != e0 || hall_signal !== 3'b101 || sector !== 3'd0 || hall_error !== 1'b0) begin
      errors++;
      $display("FAIL glitch: got edges %0d code %b sector %0d err %b want edges %0d code 101 sector 0 err 0",
               edge_cnt - e0 + e0, hall_signal, sector, hall_error, e0);
    end
  endtask

  task automatic test_invalid();
    logic [2:0] c [3];
    int         h [3];
    snap_t      ex [3];
    snap_t      es;
    int         ec;
    c = '{3'b000, 3'b101, 3'b100};
    h = '{300, 1000, 1000};
    ex[0] = mk(3'b000, 3'd7, 1'b0, 500, 1'b0, 1'b1, 1'b0);
    ex[1] = mk(3'b101, 3'd0, 1'b0, 500, 1'b0, 1'b0, 1'b0);
    ex[2] = mk(3'b100, 3'd1, 1'b1, 1000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_code(c[i], h[i], ex[i]);
      es = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      checks++;
      if (obs_timeout || obs !== es || obs_cyc != ec) begin
        errors++;
        $display("FAIL invalid[%0d]: got %h at %0d timeout %b want %h at %0d", i, obs, obs_cyc,
                 obs_timeout, es, ec);
      end
      checks++;
      if (obs_err_next !== 1'b0) begin
        errors++;
        $display("FAIL invalid[%0d] error_pulse: got %b after edge want 0", i, obs_err_next);
      end
    end
  endtask

  task automatic test_jump();
    logic [2:0] c [2];
    int         h [2];
    snap_t      ex [2];
    snap_t      es;
    int         ec;
    c = '{3'b101, 3'b010};
    h = '{1000, 500};
    ex[0] = mk(3'b101, 3'd0, 1'b0, 1000, 1'b1, 1'b0, 1'b0);
    ex[1] = mk(3'b010, 3'd3, 1'b0, 1000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      apply_code(c[i], h[i], ex[i]);
      es = exp_q.pop_front();
      ec = exp_cyc_q.pop_front();
      checks++;
      if (obs_timeout || obs !== es || obs_cyc != ec) begin
        errors++;
        $display("FAIL jump[%0d]: got %h at %0d timeout %b want %h at %0d", i, obs, obs_cyc,
                 obs_timeout, es, ec);
      end
    end
  endtask

  task automatic test_stall();
    snap_t es;
    int    ec;
    int    e0;
    int    n;
    apply_code(3'b110, 0, mk(3'b110, 3'd2, 1'b0, 1000, 1'b0, 1'b0, 1'b0));
    es = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    checks++;
    if (obs_timeout || obs !== es || obs_cyc != ec) begin
      errors++;
      $display("FAIL stall_entry_edge: got %h at %0d want %h at %0d", obs, obs_cyc, es, ec);
    end
    e0 = obs_cyc;
    n = 0;
    while (n < TO + 100 && no_feedback !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (no_feedback !== 1'b1 || cyc != e0 + TO) begin
      errors++;
      $display("FAIL stall_time: got nf %b at cycle %0d want 1 at %0d", no_feedback, cyc, e0 + TO);
    end
    checks++;
    if (period_valid !== 1'b0 || period !== PW'(1000)) begin
      errors++;
      $display("FAIL stall_period: got pv %b period %0d want pv 0 period 1000", period_valid, period);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (no_feedback !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: got nf %b want 1", no_feedback);
    end
    apply_code(3'b010, 700, mk(3'b010, 3'd3, 1'b1, 1000, 1'b0, 1'b0, 1'b0));
    es = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    checks++;
    if (obs_timeout || obs !== es || obs_cyc != ec) begin
      errors++;
      $display("FAIL stall_exit: got %h at %0d want %h at %0d", obs, obs_cyc, es, ec);
    end
    apply_code(3'b011, 300, mk(3'b011, 3'd4, 1'b1, 700, 1'b1, 1'b0, 1'b0));
    es = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    checks++;
    if (obs_timeout || obs !== es || obs_cyc != ec) begin
      errors++;
      $display("FAIL stall_recover: got %h at %0d want %h at %0d", obs, obs_cyc, es, ec);
    end
  endtask

  task automatic test_async_reset();
    snap_t r;
    snap_t es;
    int    ec;
    r = mk(3'b000, 3'd7, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (sample() !== r || hall_edge !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h edge %b want %h edge 0", sample(), hall_edge, r);
    end
    hall_raw = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    apply_code(3'b101, 100, mk(3'b101, 3'd0, 1'b1, 0, 1'b0, 1'b0, 1'b0));
    es = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    checks++;
    if (obs_timeout || obs !== es || obs_cyc != ec) begin
      errors++;
      $display("FAIL post_reset_edge: got %h at %0d want %h at %0d", obs, obs_cyc, es, ec);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_invalid();
    test_jump();
    test_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hall_feedback_monitor.md
Name: hall_feedback_monitor

Overview:
Front-end conditioning block for the BLDC motor controller's Hall inputs.
- Synchronises and debounces the raw Hall sensors.
- Decodes the commutation sector and rotation direction.
- Measures the inter-edge period for speed estimation.
- Produces the no_feedback stall indication that the motor controller's fault detection consumes.
- Sits between the motor's Hall sensor pins and the FSM controller's hall_signal/no_feedback inputs.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (min 2).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a new Hall code is accepted (min 1).
- TIMEOUT_CYCLES, 1000000, cycles without an accepted edge before stall is declared.
- PERIOD_W, 24, width of the period counter/output; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- hall_raw  input  3  unsynchronised Hall sensor pins {C,B,A}.
- hall_signal  output  3  debounced Hall code; drives the controller's hall_signal.
- sector  output  3  decoded sector 0..5; 7 = invalid code.
- direction  output  1  1 = forward, 0 = reverse.
- hall_edge  output  1  one-cycle pulse on each accepted code change.
- period  output  PERIOD_W  clk cycles between the last two accepted valid edges.
- period_valid  output  1  period holds a genuine measurement.
- hall_error  output  1  one-cycle pulse on an invalid code or an illegal sector jump.
- no_feedback  output  1  stall flag; drives the controller's no_feedback.

Behaviour:
- Reset values: hall_signal=3'b000, sector=7, direction=1, hall_edge=0, period=0, period_valid=0, hall_error=0, no_feedback=0. Internal state is ACQUIRE with all counters cleared.
- Synchroniser: SYNC_STAGES flip-flops per bit; the last stage is called sync.
- Debounce:
  - A candidate register tracks sync and a stable counter counts consecutive matching cycles.
  - If sync differs from the candidate, candidate<=sync and the counter resets to 1.
  - When the counter reaches DEBOUNCE_CYCLES and candidate≠hall_signal, hall_signal<=candidate and hall_edge pulses.
  - Latency from a clean input change to hall_edge is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES are never accepted.
- Sector map, registered together with hall_signal: 101→0, 100→1, 110→2, 010→3, 011→4, 001→5. Codes 000 and 111 map to 7.
- Direction and error rules, applied on each accepted edge:
  - new sector = old+1 mod 6: forward, direction<=1.
  - new sector = old−1 mod 6: reverse, direction<=0.
  - Any other jump between valid sectors: hall_error pulse, direction held, state returns to ACQUIRE.
  - New code invalid (sector 7): hall_error pulse, state returns to ACQUIRE.
  - Old sector 7 and new sector valid: no error, state ACQUIRE→RUN, period counter restarted.
- Period counter:
  - Increments every cycle and saturates at all-ones.
  - On an accepted valid adjacent edge in RUN: period<=count, period_valid<=1, count<=1.
  - On entering RUN from ACQUIRE: count<=1, period unchanged, period_valid<=0. The first edge has no reference point.
- State machine (ACQUIRE, RUN, STALL):
  - ACQUIRE→RUN on the first accepted valid code.
  - RUN→RUN on each adjacent edge.
  - RUN→ACQUIRE on an error.
  - RUN or ACQUIRE→STALL when count reaches TIMEOUT_CYCLES.
  - STALL→RUN on an accepted valid code; no_feedback<=0 on that transition, period_valid stays 0 until the following edge.
- no_feedback: set on entry to STALL (the cycle count==TIMEOUT_CYCLES), held until leaving STALL. On the same entry, period_valid<=0.
- Simultaneous timeout and accepted edge in the same cycle: the edge wins; no stall is declared.
- Asynchronous reset mid-operation returns everything to the reset values immediately.

Optional Feature:
- Macro: HALL_PERIOD_AVG_EN.
- When defined:
  - period reports the mean of the last four valid period measurements, computed as the sum >>2, with a PERIOD_W+2-bit accumulator and a 4-deep history shift register.
  - period_valid asserts only after four consecutive valid measurements.
  - History is cleared on ACQUIRE or STALL entry.
- When undefined: period is the single most recent measurement, as above.

Test Plan:
- Reset then forward sequence 101,100,110,010,011,001, each held 1000 cycles (DEBOUNCE_CYCLES=16, SYNC_STAGES=2):
  - hall_edge pulses 18 cycles after each change.
  - sector steps 0..5, direction=1.
  - period=1000 and period_valid=1 from the second edge on (averaged mode: from the fifth edge).
- Reverse sequence 001,011,010,… at 500-cycle spacing → direction=0, period=500, no hall_error.
- 10-cycle glitch 101→100→101 → no hall_edge, hall_signal stays 101, sector stays 0.
- Apply 000 while in RUN → one hall_error pulse, sector=7, period_valid=0. Next valid code → ACQUIRE→RUN, no error.
- Jump 101→010 (sector 0→3) → hall_error pulse, direction unchanged, period_valid=0.
- Hold a code with TIMEOUT_CYCLES=2000 → no_feedback=1 exactly 2000 cycles after the last edge. Next adjacent edge → no_feedback=0, period_valid=0 until one more edge. Assert reset=0 mid-run → all outputs return to reset values asynchronously.
